// File: rtl/arb_mux_reg.sv
// arb_mux_reg: N-input registered arbitrating mux with per-channel valid/ready.
// Grants one requester per cycle (round-robin or fixed priority) into a single
// output register stage. The held beat drains while the next beat loads.
module arb_mux_reg #(
    parameter  int WIDTH    = 64,
    parameter  int N        = 4,
    parameter  int ARB_MODE = 0,
    localparam int IDXW     = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [N*WIDTH-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [IDXW-1:0]    out_sel
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [IDXW-1:0]  out_sel_q,   out_sel_d;
    logic [IDXW-1:0]  ptr_q,       ptr_d;

    logic             accept;
    logic             grant_found;
    logic [IDXW-1:0]  grant_idx;
    logic             xfer;

    // Pick the first valid channel, scanning from ptr (round-robin) or from 0 (fixed).
    always_comb begin
        int              cand;
        logic [IDXW-1:0] cand_idx;
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int off = 0; off < N; off++) begin
            cand = (ARB_MODE == 0) ? int'(ptr_q) + off : off;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = IDXW'(cand);
            if (!grant_found && in_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // Handshake and next-state: load on a transfer, otherwise drain or hold.
    always_comb begin
        accept   = !out_valid_q || out_ready;
        in_ready = '0;
        if (!rst && accept && grant_found) begin
            in_ready[grant_idx] = 1'b1;
        end
        xfer = |in_ready;

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data[grant_idx*WIDTH +: WIDTH];
            out_sel_d   = grant_idx;
            if (ARB_MODE == 0) begin
                ptr_d = (grant_idx == IDXW'(N-1)) ? '0 : grant_idx + IDXW'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register stage and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the data register is reset too, because out_data must read 0 after reset.
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_arb_mux_reg.sv
// tb_arb_mux_reg: drives a round-robin and a fixed-priority instance with shared
// stimulus and checks both against a queue-free behavioural model every cycle.
module tb_arb_mux_reg;

    localparam int N = 4;
    localparam int W = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [N-1:0]     in_valid;
    logic [N*W-1:0]   in_data;
    logic             out_ready;

    logic [N-1:0] rr_in_ready,  fx_in_ready;
    logic         rr_out_valid, fx_out_valid;
    logic [W-1:0] rr_out_data,  fx_out_data;
    logic [1:0]   rr_out_sel,   fx_out_sel;

    arb_mux_reg #(.WIDTH(W), .N(N), .ARB_MODE(0)) dut_rr (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rr_in_ready),
        .in_data(in_data), .out_valid(rr_out_valid), .out_ready(out_ready),
        .out_data(rr_out_data), .out_sel(rr_out_sel)
    );

    arb_mux_reg #(.WIDTH(W), .N(N), .ARB_MODE(1)) dut_fx (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(fx_in_ready),
        .in_data(in_data), .out_valid(fx_out_valid), .out_ready(out_ready),
        .out_data(fx_out_data), .out_sel(fx_out_sel)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: index 0 = round-robin instance, index 1 = fixed priority.
    bit           m_init = 1'b0;
    bit           m_valid [2];
    logic [W-1:0] m_data  [2];
    int           m_sel   [2];
    int           m_ptr   [2];

    // Winning channel for instance k under the current inputs, -1 if none valid.
    function automatic int pick(input int k);
        int start;
        start = (k == 1) ? 0 : m_ptr[k];
        for (int off = 0; off < N; off++) begin
            if (in_valid[(start + off) % N]) return (start + off) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready(input int k);
        logic [N-1:0] r;
        int g;
        r = '0;
        g = pick(k);
        if (!rst && g >= 0 && (!m_valid[k] || out_ready)) r[g] = 1'b1;
        return r;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int g;
            logic [N-1:0] r;
            if (rst) begin
                m_valid[k] = 1'b0;
                m_data[k]  = '0;
                m_sel[k]   = 0;
                m_ptr[k]   = 0;
                m_init     = 1'b1;
            end else if (m_init) begin
                g = pick(k);
                r = exp_ready(k);
                if (r != '0) begin
                    m_valid[k] = 1'b1;
                    m_data[k]  = in_data[g*W +: W];
                    m_sel[k]   = g;
                    if (k == 0) m_ptr[k] = (g + 1) % N;
                end else if (out_ready) begin
                    m_valid[k] = 1'b0;
                end
            end
        end
    end

    // Compare both instances against the model on every falling edge after reset.
    always @(negedge clk) begin
        if (m_init) begin
            check("rr_in_ready",  W'(rr_in_ready),  W'(exp_ready(0)));
            check("rr_out_valid", W'(rr_out_valid), W'(m_valid[0]));
            check("rr_out_data",  rr_out_data,      m_data[0]);
            check("rr_out_sel",   W'(rr_out_sel),   W'(m_sel[0]));
            check("fx_in_ready",  W'(fx_in_ready),  W'(exp_ready(1)));
            check("fx_out_valid", W'(fx_out_valid), W'(m_valid[1]));
            check("fx_out_data",  fx_out_data,      m_data[1]);
            check("fx_out_sel",   W'(fx_out_sel),   W'(m_sel[1]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with all channels requesting.
        rst = 1'b1; in_valid = 4'hF; in_data = '0; out_ready = 1'b0;
        tick();
        @(negedge clk);
        check("reset_in_ready",    W'(rr_in_ready),  W'(4'h0));
        check("reset_fx_in_ready", W'(fx_in_ready),  W'(4'h0));
        check("reset_out_valid",   W'(rr_out_valid), W'(1'b0));
        check("reset_out_data",    rr_out_data,      64'h0);
        check("reset_out_sel",     W'(rr_out_sel),   W'(2'd0));
        tick();

        // Single beat from ch2.
        rst = 1'b0; in_valid = 4'b0100; in_data[2*W +: W] = 64'hA5; out_ready = 1'b1;
        @(negedge clk);
        check("single_in_ready", W'(rr_in_ready), W'(4'b0100));
        tick();
        in_valid = 4'b0000; rst = 1'b1;
        @(negedge clk);
        check("single_out_valid", W'(rr_out_valid), W'(1'b1));
        check("single_out_data",  rr_out_data,      64'hA5);
        check("single_out_sel",   W'(rr_out_sel),   W'(2'd2));
        tick();

        // Round-robin fairness: all valid, ch i carries data i.
        rst = 1'b0; in_valid = 4'hF;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = W'(i);
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k == 7) out_ready = 1'b0;
            @(negedge clk);
            check("rr_seq_sel",  W'(rr_out_sel), W'(k % 4));
            check("rr_seq_data", rr_out_data,    W'(k % 4));
        end

        // Backpressure: held beat ch3 stays put while out_ready is low.
        for (int j = 0; j < 5; j++) begin
            check("bp_in_ready", W'(rr_in_ready), W'(4'h0));
            check("bp_sel",      W'(rr_out_sel),  W'(2'd3));
            check("bp_data",     rr_out_data,     64'd3);
            tick();
            if (j == 4) out_ready = 1'b1;
            @(negedge clk);
        end
        check("bp_release_in_ready", W'(rr_in_ready), W'(4'b0001));
        tick();
        in_valid = 4'b1000;
        @(negedge clk);
        check("bp_no_bubble_valid", W'(rr_out_valid), W'(1'b1));
        check("bp_no_bubble_sel",   W'(rr_out_sel),   W'(2'd0));

        // Wrap-around: ch3 grant then 1001 -> ch0, ch3; ch2 grant then 1001 -> ch3, ch0.
        tick(); in_valid = 4'b1001;
        @(negedge clk); check("wrap_a0", W'(rr_out_sel), W'(2'd3));
        tick();
        @(negedge clk); check("wrap_a1", W'(rr_out_sel), W'(2'd0));
        tick(); in_valid = 4'b0100;
        @(negedge clk); check("wrap_a2", W'(rr_out_sel), W'(2'd3));
        tick(); in_valid = 4'b1001;
        @(negedge clk); check("wrap_b0", W'(rr_out_sel), W'(2'd2));
        tick();
        @(negedge clk); check("wrap_b1", W'(rr_out_sel), W'(2'd3));
        tick(); in_valid = 4'b1010;
        @(negedge clk); check("wrap_b2", W'(rr_out_sel), W'(2'd0));

        // Fixed priority: 1010 always picks ch1; dropping ch1 picks ch3.
        for (int j = 0; j < 3; j++) begin
            tick();
            if (j == 2) in_valid = 4'b1000;
            @(negedge clk);
            check("fixed_sel1", W'(fx_out_sel), W'(2'd1));
        end
        tick(); out_ready = 1'b0; in_valid = 4'b1010;
        @(negedge clk);
        check("fixed_sel3",   W'(fx_out_sel),   W'(2'd3));
        check("fixed_valid3", W'(fx_out_valid), W'(1'b1));
        tick(); rst = 1'b1;
        @(negedge clk);
        check("fixed_held_valid", W'(fx_out_valid), W'(1'b1));
        tick(); rst = 1'b0;
        @(negedge clk);
        check("fixed_rst_valid", W'(fx_out_valid), W'(1'b0));
        check("rr_rst_valid",    W'(rr_out_valid), W'(1'b0));

        // Randomised traffic with occasional reset and backpressure.
        for (int c = 0; c < 600; c++) begin
            tick();
            rst       = ($urandom_range(0, 59) == 0);
            in_valid  = ($urandom_range(0, 4) == 0) ? 4'hF : N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) in_data[i*W +: W] = {$urandom, $urandom};
            @(negedge clk);
        end

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
